morse_tx: RTL and testbench
===========================

MORSE_TX -- requirements
Module: morse_tx

Interface
REQ-001 SHALL have parameter DOT_TICKS, default 2500000, meaning clk cycles per Morse unit (legal range 1 or more).
REQ-002 SHALL have port clk, input, 1 bit: the only clock, rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port char_valid, input, 1 bit: a character code is offered.
REQ-005 SHALL have port char_code, input, 6 bits: A-Z as 0-25, digits 0-9 as 26-35, space as 36.
REQ-006 SHALL have port ready, output, 1 bit: the block can accept a code; registered.
REQ-007 SHALL have port dout, output, 1 bit: Morse keying line (1 = mark); registered.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse when a character, including its trailing gap, is complete.
REQ-009 SHALL have port err, output, 1 bit: one-cycle pulse when an illegal code is accepted.

Function
REQ-010 SHALL accept a code on any rising edge where char_valid=1 and ready=1; char_code is sampled only at that edge.
REQ-011 SHALL ignore char_valid while ready=0.
REQ-012 SHALL look up char_code into a length (1-5) and a pattern (8 bits), sent MSB-first from bit length-1, with 1 = dash and 0 = dot.
REQ-013 SHALL implement states IDLE, MARK, SPACE, CGAP and WGAP.
REQ-014 SHALL, on accepting a legal non-space code, enter MARK and drive dout=1 from that same edge, with ready=0.
REQ-015 SHALL hold MARK for exactly DOT_TICKS cycles for a dot and 3*DOT_TICKS cycles for a dash.
REQ-016 SHALL, after a mark, enter SPACE (dout=0) for DOT_TICKS cycles if elements remain, otherwise enter CGAP (dout=0) for 3*DOT_TICKS cycles.
REQ-017 SHALL, on the edge ending CGAP or WGAP, return to IDLE, set ready=1 and pulse done for one cycle.
REQ-018 SHALL therefore accept a back-to-back code at the earliest one cycle after done.
REQ-019 SHALL use a single unit down-counter sized by $clog2(7*DOT_TICKS+1) bits, with no wrap-around permitted.
REQ-020 SHALL treat codes 37-63 as illegal: consume the code, pulse err on the next cycle, keep dout=0 and ready=1, and stay in IDLE.
REQ-021 SHALL not assert done for an illegal code.

Reset
REQ-022 SHALL, on rst=1 and regardless of clk, force state=IDLE, dout=0, ready=1, done=0, err=0 and the counter to 0.
REQ-023 SHALL abort any character in progress on reset mid-character, with no done pulse.
REQ-024 SHALL allow acceptance on the first rising edge after rst deasserts.

Configuration
REQ-025 SHALL, with MORSE_TX_WORDGAP_EN defined, treat code 36 as legal: enter WGAP with dout=0 for 7*DOT_TICKS cycles, then apply REQ-017.
REQ-026 SHALL, without MORSE_TX_WORDGAP_EN, treat code 36 as illegal per REQ-020.

Structure
REQ-027 SHALL take the following from shared package morse_pkg: code width, the code constants (CODE_A=0, CODE_DIGIT0=26, CODE_SPACE=36), the element encoding (DOT=0, DASH=1), the tx state enum, and max length 8.
REQ-028 SHALL place code-to-(length, pattern) in combinational sub-module morse_enc_lut, the inverse of the receive-side decode table.

Verification (DOT_TICKS=2)
REQ-029 SHALL cover 'E' (code 4): dout=1 for 2 cycles, then 0 for 6 cycles, then done for 1 cycle with ready=1.
REQ-030 SHALL cover 'A' (code 0): dout pattern 1,1,0,0,1,1,1,1,1,1 followed by six 0s, then done; 16 cycles from acceptance to done.
REQ-031 SHALL cover '0' (code 26): five 6-cycle marks separated by 2-cycle spaces, then a 6-cycle gap, then done; 44 cycles total.
REQ-032 SHALL cover code 40: err=1 for one cycle, dout stays 0, ready stays 1, done never asserts.
REQ-033 SHALL cover rst asserted 3 cycles into the dash of 'T' (code 19): dout=0 and ready=1 immediately, no done, and a following 'E' is sent correctly.
REQ-034 SHALL cover code 36: with the macro, 14 cycles of dout=0 then done; without the macro, an err pulse.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared Morse transmit definitions: code map, element encoding, tx states.
package morse_pkg;

    localparam int CODE_W  = 6;
    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 3;

    localparam logic [CODE_W-1:0] CODE_A      = 6'd0;
    localparam logic [CODE_W-1:0] CODE_DIGIT0 = 6'd26;
    localparam logic [CODE_W-1:0] CODE_SPACE  = 6'd36;

    localparam logic DOT  = 1'b0;
    localparam logic DASH = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MARK,
        ST_SPACE,
        ST_CGAP,
        ST_WGAP
    } tx_state_e;

endpackage

// File: rtl/morse_tx_if.sv
// Character handshake and keying outputs of the Morse transmitter.
interface morse_tx_if;
    import morse_pkg::*;

    logic              char_valid;
    logic [CODE_W-1:0] char_code;
    logic              ready;
    logic              dout;
    logic              done;
    logic              err;

    modport master (
        output char_valid, char_code,
        input  ready, dout, done, err
    );

    modport slave (
        input  char_valid, char_code,
        output ready, dout, done, err
    );

endinterface

// File: rtl/morse_enc_lut.sv
// Code to (length, pattern) table; pattern sent MSB-first from bit len-1.
module morse_enc_lut
    import morse_pkg::*;
(
    input  logic [CODE_W-1:0]  code,
    output logic               ok,
    output logic [LEN_W-1:0]   len,
    output logic [MAX_LEN-1:0] pat
);

    always_comb begin
        ok  = (code < CODE_SPACE);
        len = '0;
        pat = '0;
        unique case (code)
            6'd0:  {len, pat} = {3'd2, 8'b01};
            6'd1:  {len, pat} = {3'd4, 8'b1000};
            6'd2:  {len, pat} = {3'd4, 8'b1010};
            6'd3:  {len, pat} = {3'd3, 8'b100};
            6'd4:  {len, pat} = {3'd1, 8'b0};
            6'd5:  {len, pat} = {3'd4, 8'b0010};
            6'd6:  {len, pat} = {3'd3, 8'b110};
            6'd7:  {len, pat} = {3'd4, 8'b0000};
            6'd8:  {len, pat} = {3'd2, 8'b00};
            6'd9:  {len, pat} = {3'd4, 8'b0111};
            6'd10: {len, pat} = {3'd3, 8'b101};
            6'd11: {len, pat} = {3'd4, 8'b0100};
            6'd12: {len, pat} = {3'd2, 8'b11};
            6'd13: {len, pat} = {3'd2, 8'b10};
            6'd14: {len, pat} = {3'd3, 8'b111};
            6'd15: {len, pat} = {3'd4, 8'b0110};
            6'd16: {len, pat} = {3'd4, 8'b1101};
            6'd17: {len, pat} = {3'd3, 8'b010};
            6'd18: {len, pat} = {3'd3, 8'b000};
            6'd19: {len, pat} = {3'd1, 8'b1};
            6'd20: {len, pat} = {3'd3, 8'b001};
            6'd21: {len, pat} = {3'd4, 8'b0001};
            6'd22: {len, pat} = {3'd3, 8'b011};
            6'd23: {len, pat} = {3'd4, 8'b1001};
            6'd24: {len, pat} = {3'd4, 8'b1011};
            6'd25: {len, pat} = {3'd4, 8'b1100};
            6'd26: {len, pat} = {3'd5, 8'b11111};
            6'd27: {len, pat} = {3'd5, 8'b01111};
            6'd28: {len, pat} = {3'd5, 8'b00111};
            6'd29: {len, pat} = {3'd5, 8'b00011};
            6'd30: {len, pat} = {3'd5, 8'b00001};
            6'd31: {len, pat} = {3'd5, 8'b00000};
            6'd32: {len, pat} = {3'd5, 8'b10000};
            6'd33: {len, pat} = {3'd5, 8'b11000};
            6'd34: {len, pat} = {3'd5, 8'b11100};
            6'd35: {len, pat} = {3'd5, 8'b11110};
            default: ;
        endcase
    end

endmodule

// File: rtl/morse_tx.sv
// Morse keyer: one character per handshake, unit-timed marks and gaps.
// Define MORSE_TX_WORDGAP_EN to send code 36 as a 7-unit word gap.
module morse_tx
    import morse_pkg::*;
#(
    parameter int DOT_TICKS = 2500000
) (
    input  logic       clk,
    input  logic       rst,
    morse_tx_if.slave  bus
);

    localparam int CW = $clog2(7 * DOT_TICKS + 1);

    localparam logic [CW-1:0] LD_DOT  = CW'(DOT_TICKS - 1);
    localparam logic [CW-1:0] LD_DASH = CW'(3 * DOT_TICKS - 1);
    localparam logic [CW-1:0] LD_WORD = CW'(7 * DOT_TICKS - 1);

    tx_state_e          state, state_n;
    logic [CW-1:0]      cnt, cnt_n;
    logic [MAX_LEN-1:0] pat, pat_n;
    logic [LEN_W-1:0]   idx, idx_n;
    logic               dout_q, dout_n;
    logic               ready_q, ready_n;
    logic               done_q, done_n;
    logic               err_q, err_n;

    logic               lut_ok;
    logic [LEN_W-1:0]   lut_len;
    logic [MAX_LEN-1:0] lut_pat;
    logic [LEN_W-1:0]   lut_top;
    logic               accept;
    logic               is_space;

    morse_enc_lut u_lut (
        .code (bus.char_code),
        .ok   (lut_ok),
        .len  (lut_len),
        .pat  (lut_pat)
    );

    assign accept   = bus.char_valid & ready_q;
    assign is_space = (bus.char_code == CODE_SPACE);
    assign lut_top  = lut_len - 3'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            pat     <= '0;
            idx     <= '0;
            dout_q  <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            pat     <= pat_n;
            idx     <= idx_n;
            dout_q  <= dout_n;
            ready_q <= ready_n;
            done_q  <= done_n;
            err_q   <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pat_n   = pat;
        idx_n   = idx;
        dout_n  = dout_q;
        ready_n = ready_q;
        done_n  = 1'b0;
        err_n   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (lut_ok) begin
                        state_n = ST_MARK;
                        pat_n   = lut_pat;
                        idx_n   = lut_top;
                        cnt_n   = (lut_pat[lut_top] == DASH) ? LD_DASH : LD_DOT;
                        dout_n  = 1'b1;
                        ready_n = 1'b0;
`ifdef MORSE_TX_WORDGAP_EN
                    end else if (is_space) begin
                        state_n = ST_WGAP;
                        cnt_n   = LD_WORD;
                        dout_n  = 1'b0;
                        ready_n = 1'b0;
`endif
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            ST_MARK: begin
                if (cnt == '0) begin
                    dout_n = 1'b0;
                    if (idx != '0) begin
                        state_n = ST_SPACE;
                        cnt_n   = LD_DOT;
                        idx_n   = idx - 3'd1;
                    end else begin
                        state_n = ST_CGAP;
                        cnt_n   = LD_DASH;
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            ST_SPACE: begin
                if (cnt == '0) begin
                    state_n = ST_MARK;
                    dout_n  = 1'b1;
                    cnt_n   = (pat[idx] == DASH) ? LD_DASH : LD_DOT;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            ST_CGAP, ST_WGAP: begin
                if (cnt == '0) begin
                    state_n = ST_IDLE;
                    ready_n = 1'b1;
                    done_n  = 1'b1;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Space codes are only consumed through the error path in the default build.
    logic unused_space;
    assign unused_space = is_space;

    assign bus.ready = ready_q;
    assign bus.dout  = dout_q;
    assign bus.done  = done_q;
    assign bus.err   = err_q;

endmodule

// File: tb/tb_morse_tx.sv
// Randomized checks of morse_tx against a dot/dash string reference model.
module tb_morse_tx;

    localparam int D = 2;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    morse_tx_if bus ();

    morse_tx #(.DOT_TICKS(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    string tab [36] = '{
        ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
        ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
        "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--..",
        "-----", ".----", "..---", "...--", "....-",
        ".....", "-....", "--...", "---..", "----."
    };

    function automatic bit is_legal(input int code);
`ifdef MORSE_TX_WORDGAP_EN
        return code <= 36;
`else
        return code < 36;
`endif
    endfunction

    // Expected keying waveform, one entry per clock from acceptance to done.
    function automatic void build(input int code, output bit q[$]);
        string s;
        q = {};
        if (code == 36) begin
            for (int k = 0; k < 7 * D; k++) q.push_back(1'b0);
            return;
        end
        s = tab[code];
        for (int j = 0; j < s.len(); j++) begin
            if (j > 0)
                for (int k = 0; k < D; k++) q.push_back(1'b0);
            for (int k = 0; k < ((s[j] == "-") ? 3 * D : D); k++)
                q.push_back(1'b1);
        end
        for (int k = 0; k < 3 * D; k++) q.push_back(1'b0);
    endfunction

    task automatic wait_ready();
        int n;
        n = 0;
        while (bus.ready !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        vectors++;
        if (bus.ready !== 1'b1) begin
            miscompares++;
            $display("FAIL wait_ready: ready=%b required 1", bus.ready);
        end
    endtask

    task automatic send(input int code, input bit junk);
        bit q[$];
        wait_ready();
        bus.char_valid = 1'b1;
        bus.char_code  = 6'(code);
        @(posedge clk);
        #1;
        if (junk) bus.char_code = 6'd40;
        else bus.char_valid = 1'b0;
        if (!is_legal(code)) begin
            bus.char_valid = 1'b0;
            vectors++;
            if (bus.err !== 1'b1 || bus.ready !== 1'b1 ||
                bus.dout !== 1'b0 || bus.done !== 1'b0) begin
                miscompares++;
                $display("FAIL illegal code %0d: err=%b ready=%b dout=%b done=%b required 1 1 0 0",
                         code, bus.err, bus.ready, bus.dout, bus.done);
            end
            @(posedge clk);
            #1;
            vectors++;
            if (bus.err !== 1'b0 || bus.done !== 1'b0 || bus.dout !== 1'b0) begin
                miscompares++;
                $display("FAIL illegal code %0d after: err=%b done=%b dout=%b required 0 0 0",
                         code, bus.err, bus.done, bus.dout);
            end
            return;
        end
        build(code, q);
        for (int i = 0; i < q.size(); i++) begin
            vectors++;
            if (bus.dout !== q[i] || bus.ready !== 1'b0 ||
                bus.done !== 1'b0 || bus.err !== 1'b0) begin
                miscompares++;
                $display("FAIL code %0d cycle %0d: dout=%b ready=%b done=%b err=%b required %b 0 0 0",
                         code, i, bus.dout, bus.ready, bus.done, bus.err, q[i]);
            end
            if (i == q.size() - 1) bus.char_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        vectors++;
        if (bus.done !== 1'b1 || bus.ready !== 1'b1 || bus.dout !== 1'b0) begin
            miscompares++;
            $display("FAIL code %0d done: done=%b ready=%b dout=%b required 1 1 0",
                     code, bus.done, bus.ready, bus.dout);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.char_valid = 1'b0;
        bus.char_code  = '0;
        #12;
        vectors++;
        if (bus.ready !== 1'b1 || bus.dout !== 1'b0 ||
            bus.done !== 1'b0 || bus.err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: ready=%b dout=%b done=%b err=%b required 1 0 0 0",
                     bus.ready, bus.dout, bus.done, bus.err);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(4, 1'b0);
    endtask

    task automatic test_directed();
        send(0, 1'b0);
        send(26, 1'b0);
        send(40, 1'b0);
        send(36, 1'b0);
        send(4, 1'b1);
    endtask

    task automatic test_abort();
        wait_ready();
        bus.char_valid = 1'b1;
        bus.char_code  = 6'd19;
        @(posedge clk);
        #1;
        bus.char_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        vectors++;
        if (bus.dout !== 1'b1) begin
            miscompares++;
            $display("FAIL abort pre: dout=%b required 1", bus.dout);
        end
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (bus.dout !== 1'b0 || bus.ready !== 1'b1 || bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL abort: dout=%b ready=%b done=%b required 0 1 0",
                     bus.dout, bus.ready, bus.done);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) begin
            vectors++;
            if (bus.done !== 1'b0 || bus.dout !== 1'b0 || bus.ready !== 1'b1) begin
                miscompares++;
                $display("FAIL abort idle: done=%b dout=%b ready=%b required 0 0 1",
                         bus.done, bus.dout, bus.ready);
            end
            @(posedge clk);
            #1;
        end
        send(4, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++)
            send(int'($urandom_range(0, 63)), bit'($urandom_range(0, 1)));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_directed();
        test_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
